// File: rtl/tx_fifo_ctrl.sv
// tx_fifo_ctrl
//   Single-clock controller for the PCS TX FIFO RAM. It owns the write and
//   read pointers, drives the dual-port RAM address and write-enable lines,
//   registers the RAM's combinational read data into a valid/ready output
//   stage, and reports occupancy, thresholds and sticky error flags.
//
// Ports
//   wclk, wrst          clock (rising edge), synchronous active-high reset
//   flush               synchronous clear of pointers and output stage
//   clr_err             clears the sticky overflow/underrun flags
//   in_valid, in_ready  upstream (TX encoder) handshake
//   mem_waddr/raddr     RAM write/read addresses
//   mem_wclken          RAM write enable (one word accepted this cycle)
//   mem_wfull           RAM write inhibit (FIFO full)
//   mem_rdata           RAM combinational read data at mem_raddr
//   out_valid/data/ready  downstream (gearbox/scrambler) handshake
//   count               RAM occupancy 0..DEPTH, excluding the output register
//   almost_full/empty   threshold flags derived from count
//   overflow, underrun  sticky error flags
module tx_fifo_ctrl #(
  parameter int unsigned DATASIZE  = 264,
  parameter int unsigned ADDRSIZE  = 5,
  parameter int unsigned AFULL_TH  = 28,
  parameter int unsigned AEMPTY_TH = 4
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                flush,
  input  logic                clr_err,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [ADDRSIZE-1:0] mem_waddr,
  output logic [ADDRSIZE-1:0] mem_raddr,
  output logic                mem_wclken,
  output logic                mem_wfull,
  input  logic [DATASIZE-1:0] mem_rdata,
  output logic                out_valid,
  output logic [DATASIZE-1:0] out_data,
  input  logic                out_ready,
  output logic [ADDRSIZE:0]   count,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underrun
);

  localparam logic [ADDRSIZE:0] PTR_ONE = (ADDRSIZE+1)'(1);
  localparam logic [ADDRSIZE:0] AF_TH   = (ADDRSIZE+1)'(AFULL_TH);
  localparam logic [ADDRSIZE:0] AE_TH   = (ADDRSIZE+1)'(AEMPTY_TH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDRSIZE:0] wptr;
  logic [ADDRSIZE:0] rptr;
  logic              primed;
  logic              empty;
  logic              full;
  logic              accept;
  logic              load;
  logic              ovf_set;
  logic              udr_set;

  always_comb begin
    empty   = (wptr == rptr);
    full    = (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]) &&
              (wptr[ADDRSIZE] != rptr[ADDRSIZE]);
    accept  = in_valid && !full && !flush;
    // The output register refills whenever it is empty or being drained,
    // which gives one read per cycle without a bubble.
    load    = !empty && (!out_valid || out_ready) && !flush;
    ovf_set = in_valid && full && !flush;
    udr_set = primed && out_ready && !out_valid;
  end

  // in_ready depends only on registered pointers, never on out_ready.
  assign in_ready     = !full;
  assign mem_wclken   = accept;
  assign mem_wfull    = full;
  assign mem_waddr    = wptr[ADDRSIZE-1:0];
  assign mem_raddr    = rptr[ADDRSIZE-1:0];
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  always_ff @(posedge wclk) begin
    if (wrst || flush) begin
      wptr      <= '0;
      rptr      <= '0;
      out_valid <= 1'b0;
      primed    <= 1'b0;
    end else begin
      if (accept) begin
        wptr <= wptr + PTR_ONE;
      end
      if (load) begin
        rptr      <= rptr + PTR_ONE;
        out_valid <= 1'b1;
        primed    <= 1'b1;
      end else if (out_ready && out_valid) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Data is only captured on a load; a plain drain leaves the last word in place.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= mem_rdata;
    end
  end

  // Sticky flags survive flush; a set in the same cycle as clr_err wins.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overflow <= (overflow && !clr_err) || ovf_set;
      underrun <= (underrun && !clr_err) || udr_set;
    end
  end

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
module tb_tx_fifo_ctrl;

  localparam int unsigned DW = 264;
  localparam int unsigned AW = 5;

  logic          wclk = 1'b0;
  logic          wrst, flush, clr_err, in_valid, out_ready;
  logic          in_ready, mem_wclken, mem_wfull, out_valid;
  logic          almost_full, almost_empty, overflow, underrun;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [AW:0]   count;
  logic [DW-1:0] mem_rdata, out_data, in_data;

  // Behavioural dual-port RAM: synchronous write, combinational read.
  logic [DW-1:0] ram [32];

  int total = 0;
  int bad   = 0;

  tx_fifo_ctrl #(
    .DATASIZE (DW),
    .ADDRSIZE (AW),
    .AFULL_TH (28),
    .AEMPTY_TH(4)
  ) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .flush       (flush),
    .clr_err     (clr_err),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_waddr   (mem_waddr),
    .mem_raddr   (mem_raddr),
    .mem_wclken  (mem_wclken),
    .mem_wfull   (mem_wfull),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underrun    (underrun)
  );

  always #5 wclk = ~wclk;

  always @(posedge wclk) begin
    if (mem_wclken) ram[mem_waddr] <= in_data;
  end
  assign mem_rdata = ram[mem_raddr];

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] bword(input logic [7:0] b);
    return {33{b}};
  endfunction

  function automatic logic [DW-1:0] mkword(input int unsigned n);
    logic [31:0] h;
    h = n * 32'h9E37_79B9;
    return {n[31:0], 232'(h)};
  endfunction

  initial begin
    int unsigned exp_cnt;

    wrst = 1'b1; flush = 1'b0; clr_err = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick(); tick();
    wrst = 1'b0;
    #1;

    // Reset state
    chk("rst_in_ready", DW'(in_ready), DW'(1));
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_count", DW'(count), DW'(0));
    chk("rst_afull", DW'(almost_full), DW'(0));
    chk("rst_aempty", DW'(almost_empty), DW'(1));
    chk("rst_wclken", DW'(mem_wclken), DW'(0));
    chk("rst_wfull", DW'(mem_wfull), DW'(0));
    chk("rst_waddr", DW'(mem_waddr), DW'(0));
    chk("rst_raddr", DW'(mem_raddr), DW'(0));
    chk("rst_ovf", DW'(overflow), DW'(0));
    chk("rst_udr", DW'(underrun), DW'(0));
    chk("rst_odata", out_data, '0);

    // Single word latency
    in_valid = 1'b1; in_data = bword(8'hA5);
    #1 chk("w1_wclken", DW'(mem_wclken), DW'(1));
    tick();                                   // E0: write
    in_valid = 1'b0;
    chk("w1_ov_e0", DW'(out_valid), DW'(0));
    chk("w1_cnt_e0", DW'(count), DW'(1));
    tick();                                   // E1: load
    chk("w1_ov_e1", DW'(out_valid), DW'(1));
    chk("w1_data", out_data, bword(8'hA5));
    chk("w1_cnt_e1", DW'(count), DW'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("w1_drain", DW'(out_valid), DW'(0));
    chk("w1_drain_data", out_data, bword(8'hA5));

    // Fill: 33 words with out_ready low (one sits in the output register)
    in_valid = 1'b1;
    for (int i = 0; i < 33; i++) begin
      in_data = bword(8'(8'h10 + i));
      tick();
      exp_cnt = (i == 0) ? 1 : i;
      chk($sformatf("fill_cnt%0d", i), DW'(count), DW'(exp_cnt));
      chk($sformatf("fill_af%0d", i), DW'(almost_full), DW'(exp_cnt >= 28));
      chk($sformatf("fill_ae%0d", i), DW'(almost_empty), DW'(exp_cnt <= 4));
    end
    chk("full_in_ready", DW'(in_ready), DW'(0));
    chk("full_wfull", DW'(mem_wfull), DW'(1));
    chk("full_wclken", DW'(mem_wclken), DW'(0));
    chk("full_ovf_pre", DW'(overflow), DW'(0));
    tick();                                   // 34th in_valid while full
    chk("full_ovf", DW'(overflow), DW'(1));
    chk("full_cnt", DW'(count), DW'(32));
    chk("full_word0", out_data, bword(8'h10));
    chk("full_waddr", DW'(mem_waddr), DW'(2));
    chk("full_raddr", DW'(mem_raddr), DW'(2));

    // Load at full: in_ready stays low that cycle, write goes in next cycle
    out_ready = 1'b1;
    #1 chk("fl_in_ready", DW'(in_ready), DW'(0));
    tick();
    chk("fl_word1", out_data, bword(8'h11));
    chk("fl_cnt31", DW'(count), DW'(31));
    chk("fl_in_ready2", DW'(in_ready), DW'(1));
    tick();
    chk("fl_word2", out_data, bword(8'h12));
    chk("fl_cnt_same", DW'(count), DW'(31));
    in_valid = 1'b0; out_ready = 1'b0;

    // Flush keeps sticky overflow; clr_err then clears it
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl1_cnt", DW'(count), DW'(0));
    chk("fl1_ov", DW'(out_valid), DW'(0));
    chk("fl1_ovf_kept", DW'(overflow), DW'(1));
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_ovf", DW'(overflow), DW'(0));
    chk("clr_udr", DW'(underrun), DW'(0));

    // Streaming: 200 cycles, one write and one read per cycle
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      in_data = mkword(k - 1);
      tick();
      chk($sformatf("st_cnt%0d", k), DW'(count), DW'(1));
      if (k >= 2) begin
        chk($sformatf("st_ov%0d", k), DW'(out_valid), DW'(1));
        chk($sformatf("st_data%0d", k), out_data, mkword(k - 2));
      end
    end
    chk("st_ovf", DW'(overflow), DW'(0));
    chk("st_udr", DW'(underrun), DW'(0));
    chk("st_waddr", DW'(mem_waddr), DW'(8));
    chk("st_raddr", DW'(mem_raddr), DW'(7));

    // Underrun after priming
    in_valid = 1'b0;
    tick();
    chk("ud_last", out_data, mkword(199));
    chk("ud_cnt0", DW'(count), DW'(0));
    tick();
    chk("ud_ov0", DW'(out_valid), DW'(0));
    chk("ud_not_yet", DW'(underrun), DW'(0));
    tick();
    chk("ud_set", DW'(underrun), DW'(1));
    clr_err = 1'b1;                           // set condition still present
    tick();
    chk("ud_set_wins", DW'(underrun), DW'(1));
    out_ready = 1'b0;
    tick();
    clr_err = 1'b0;
    chk("ud_clr", DW'(underrun), DW'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ud_reset", DW'(underrun), DW'(1));

    // Flush together with in_valid and out_ready at count=10
    in_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_data = mkword(300 + i);
      tick();
    end
    chk("f2_cnt10", DW'(count), DW'(10));
    chk("f2_ae0", DW'(almost_empty), DW'(0));
    flush = 1'b1; out_ready = 1'b1;
    #1 chk("f2_nowrite", DW'(mem_wclken), DW'(0));
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("f2_cnt", DW'(count), DW'(0));
    chk("f2_ov", DW'(out_valid), DW'(0));
    chk("f2_waddr", DW'(mem_waddr), DW'(0));
    chk("f2_raddr", DW'(mem_raddr), DW'(0));
    chk("f2_ae", DW'(almost_empty), DW'(1));
    chk("f2_udr_kept", DW'(underrun), DW'(1));
    chk("f2_ovf_kept", DW'(overflow), DW'(0));

    // Reset mid-stream at count=17
    in_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      in_data = mkword(500 + i);
      tick();
    end
    chk("r2_cnt17", DW'(count), DW'(17));
    chk("r2_ov1", DW'(out_valid), DW'(1));
    wrst = 1'b1; out_ready = 1'b1;
    tick();
    wrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("r2_in_ready", DW'(in_ready), DW'(1));
    chk("r2_ov", DW'(out_valid), DW'(0));
    chk("r2_cnt", DW'(count), DW'(0));
    chk("r2_af", DW'(almost_full), DW'(0));
    chk("r2_ae", DW'(almost_empty), DW'(1));
    chk("r2_wclken", DW'(mem_wclken), DW'(0));
    chk("r2_wfull", DW'(mem_wfull), DW'(0));
    chk("r2_waddr", DW'(mem_waddr), DW'(0));
    chk("r2_raddr", DW'(mem_raddr), DW'(0));
    chk("r2_ovf", DW'(overflow), DW'(0));
    chk("r2_udr", DW'(underrun), DW'(0));
    chk("r2_odata", out_data, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
